// File: rtl/dna_sw_pkg.sv
// Shared types and saturating score arithmetic for the systolic DNA aligner.
// Scores are handled as 32-bit signed intermediates and clamped to the configured width.
package dna_sw_pkg;

    typedef enum logic [1:0] {
        NT_A = 2'b00,
        NT_C = 2'b01,
        NT_G = 2'b10,
        NT_T = 2'b11
    } nt_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_REF,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic               hit;
        logic signed [31:0] value;
    } sat_t;

    // Clamp a + b into a signed w-bit range; hit flags any clamping.
    function automatic sat_t sat_add(input logic signed [31:0] a,
                                     input logic signed [31:0] b,
                                     input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        logic signed [31:0] sum;
        sat_t r;
        hi      = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo      = -hi - 32'sd1;
        sum     = a + b;
        r.hit   = 1'b0;
        r.value = sum;
        if (sum > hi) begin
            r.hit   = 1'b1;
            r.value = hi;
        end else if (sum < lo) begin
            r.hit   = 1'b1;
            r.value = lo;
        end
        return r;
    endfunction

    function automatic sat_t sat_sub(input logic signed [31:0] a,
                                     input logic signed [31:0] b,
                                     input int w);
        return sat_add(a, -b, w);
    endfunction

    function automatic logic signed [31:0] subst_score(input nt_e rd,
                                                       input nt_e rf,
                                                       input logic [2:0] match,
                                                       input logic [2:0] mismatch);
        return (rd == rf) ? $signed({29'd0, match}) : -$signed({29'd0, mismatch});
    endfunction

endpackage

// File: rtl/dna_sw_pe.sv
// One systolic cell: holds a reference base, its column's last H value and the diagonal
// neighbour; read symbols and their row tags ripple through one cell per valid beat.
module dna_sw_pe
    import dna_sw_pkg::*;
#(
    parameter int SCORE_W = 16,
    parameter int READ_W  = 11
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      init,
    input  logic signed [SCORE_W-1:0] init_h,
    input  logic signed [SCORE_W-1:0] init_diag,
    input  logic                      ref_we,
    input  nt_e                       ref_sym,
    input  logic                      local_mode,
    input  logic [2:0]                match,
    input  logic [2:0]                mismatch,
    input  logic [2:0]                gap,
    input  logic                      valid_in,
    input  nt_e                       sym_in,
    input  logic [READ_W-1:0]         row_in,
    input  logic signed [SCORE_W-1:0] h_left,
    output logic                      valid_out,
    output nt_e                       sym_out,
    output logic [READ_W-1:0]         row_out,
    output logic signed [SCORE_W-1:0] h_out,
    output logic                      sat
);

    nt_e                       ref_reg;
    logic signed [SCORE_W-1:0] h_reg;
    logic signed [SCORE_W-1:0] diag_reg;
    logic signed [31:0]        diag_x, up_x, left_x, gap_x;
    logic signed [31:0]        cand_diag, cand_up, cand_left, best_x;
    sat_t                      c_diag, c_up, c_left;

    always_comb begin
        diag_x    = {{(32-SCORE_W){diag_reg[SCORE_W-1]}}, diag_reg};
        up_x      = {{(32-SCORE_W){h_reg[SCORE_W-1]}}, h_reg};
        left_x    = {{(32-SCORE_W){h_left[SCORE_W-1]}}, h_left};
        gap_x     = $signed({29'd0, gap});
        c_diag    = sat_add(diag_x, subst_score(sym_in, ref_reg, match, mismatch), SCORE_W);
        c_up      = sat_sub(up_x, gap_x, SCORE_W);
        c_left    = sat_sub(left_x, gap_x, SCORE_W);
        cand_diag = c_diag.value;
        cand_up   = c_up.value;
        cand_left = c_left.value;
        best_x    = cand_diag;
        if (cand_up > best_x) begin
            best_x = cand_up;
        end
        if (cand_left > best_x) begin
            best_x = cand_left;
        end
        if (local_mode && (best_x < 32'sd0)) begin
            best_x = 32'sd0;
        end
        sat = valid_in & (c_diag.hit | c_up.hit | c_left.hit);
    end

    // Bubbles only advance the valid pipe; scores, diagonal and tags stay put.
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_reg   <= NT_A;
            h_reg     <= '0;
            diag_reg  <= '0;
            valid_out <= 1'b0;
            sym_out   <= NT_A;
            row_out   <= '0;
        end else begin
            valid_out <= valid_in & ~init;
            if (ref_we) begin
                ref_reg <= ref_sym;
            end
            if (init) begin
                h_reg    <= init_h;
                diag_reg <= init_diag;
            end else if (valid_in) begin
                h_reg    <= best_x[SCORE_W-1:0];
                diag_reg <= h_left;
                sym_out  <= sym_in;
                row_out  <= row_in;
            end
        end
    end

    assign h_out = h_reg;

endmodule

// File: rtl/dna_sw_systolic.sv
// Linear systolic Smith-Waterman / Needleman-Wunsch scorer: reference held in the PE chain,
// read streamed through; reports best score, end coordinates and a sticky saturation flag.
module dna_sw_systolic
    import dna_sw_pkg::*;
#(
    parameter int NUM_PE       = 16,
    parameter int SCORE_W      = 16,
    parameter int MAX_READ_LEN = 1024,
    localparam int READ_W      = $clog2(MAX_READ_LEN + 1),
    localparam int POS_W       = $clog2(NUM_PE + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start_i,
    input  logic                      mode_i,
    input  logic [2:0]                match_i,
    input  logic [2:0]                mismatch_i,
    input  logic [2:0]                gap_i,
    input  logic                      ref_valid_i,
    output logic                      ref_ready_o,
    input  logic [1:0]                ref_sym_i,
    input  logic                      ref_last_i,
    input  logic                      read_valid_i,
    output logic                      read_ready_o,
    input  logic [1:0]                read_sym_i,
    input  logic                      read_last_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic signed [SCORE_W-1:0] best_score_o,
    output logic [POS_W-1:0]          best_ref_pos_o,
    output logic [READ_W-1:0]         best_read_pos_o,
    output logic                      overflow_o
);

    state_e                    state_reg, state_next;
    logic                      mode_reg;
    logic [2:0]                match_reg, mis_reg, gap_reg;
    logic [POS_W-1:0]          ref_cnt_reg, ref_len_reg, drain_cnt_reg;
    logic [READ_W-1:0]         read_cnt_reg;
    logic signed [SCORE_W-1:0] col0_reg, col0_next;
    logic signed [SCORE_W-1:0] best_score_reg, best_score_next;
    logic [POS_W-1:0]          best_ref_reg, best_ref_next;
    logic [READ_W-1:0]         best_read_reg, best_read_next;
    logic                      ovf_reg, ovf_next;
    logic                      ref_acc, ref_end, read_acc, read_end;
    sat_t                      col0_sat;

    // Index 0 is the injection point; index j+1 is the output of PE j.
    logic                      valid_ch [NUM_PE+1];
    nt_e                       sym_ch   [NUM_PE+1];
    logic [READ_W-1:0]         row_ch   [NUM_PE+1];
    logic signed [SCORE_W-1:0] h_ch     [NUM_PE+1];
    logic signed [SCORE_W-1:0] init_ch  [NUM_PE+1];
    logic [NUM_PE-1:0]         sat_vec, pe_mask, pe_last;

    assign ref_ready_o  = (state_reg == ST_LOAD_REF);
    assign read_ready_o = (state_reg == ST_STREAM);
    assign busy_o       = (state_reg != ST_IDLE) && (state_reg != ST_DONE);
    assign done_o       = (state_reg == ST_DONE);
    assign ref_acc      = ref_valid_i & ref_ready_o;
    assign ref_end      = ref_acc & (ref_last_i | (ref_cnt_reg == POS_W'(NUM_PE - 1)));
    assign read_acc     = read_valid_i & read_ready_o;
    assign read_end     = read_acc & (read_last_i | (read_cnt_reg == READ_W'(MAX_READ_LEN - 1)));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:     if (start_i) state_next = ST_LOAD_REF;
            ST_LOAD_REF: if (ref_end) state_next = ST_STREAM;
            ST_STREAM:   if (read_end) state_next = ST_DRAIN;
            ST_DRAIN:    if (drain_cnt_reg == POS_W'(1)) state_next = ST_DONE;
            ST_DONE:     state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    // Column-0 boundary for the row entering PE0: H(i,0) = H(i-1,0) - gap in global mode.
    always_comb begin
        col0_sat  = sat_sub({{(32-SCORE_W){col0_reg[SCORE_W-1]}}, col0_reg},
                            $signed({29'd0, gap_reg}), SCORE_W);
        col0_next = mode_reg ? '0 : col0_sat.value[SCORE_W-1:0];
    end

    assign valid_ch[0] = read_acc;
    assign sym_ch[0]   = nt_e'(read_sym_i);
    assign row_ch[0]   = read_cnt_reg + 1'b1;
    assign h_ch[0]     = col0_next;
    assign init_ch[0]  = '0;

    generate
        for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_pe
            logic signed [31:0] prev_x;
            sat_t               init_sat;

            // Row-0 boundary chain: H(0,j+1) = H(0,j) - gap in global mode.
            always_comb begin
                prev_x          = {{(32-SCORE_W){init_ch[gi][SCORE_W-1]}}, init_ch[gi]};
                init_sat        = sat_sub(prev_x, $signed({29'd0, gap_reg}), SCORE_W);
                init_ch[gi + 1] = mode_reg ? '0 : init_sat.value[SCORE_W-1:0];
            end

            assign pe_mask[gi] = (POS_W'(gi) < ref_len_reg);
            assign pe_last[gi] = (POS_W'(gi + 1) == ref_len_reg);

            dna_sw_pe #(
                .SCORE_W (SCORE_W),
                .READ_W  (READ_W)
            ) u_pe (
                .clk        (clk),
                .rst        (rst),
                .init       (state_reg == ST_LOAD_REF),
                .init_h     (init_ch[gi + 1]),
                .init_diag  (init_ch[gi]),
                .ref_we     (ref_acc && (ref_cnt_reg == POS_W'(gi))),
                .ref_sym    (nt_e'(ref_sym_i)),
                .local_mode (mode_reg),
                .match      (match_reg),
                .mismatch   (mis_reg),
                .gap        (gap_reg),
                .valid_in   (valid_ch[gi]),
                .sym_in     (sym_ch[gi]),
                .row_in     (row_ch[gi]),
                .h_left     (h_ch[gi]),
                .valid_out  (valid_ch[gi + 1]),
                .sym_out    (sym_ch[gi + 1]),
                .row_out    (row_ch[gi + 1]),
                .h_out      (h_ch[gi + 1]),
                .sat        (sat_vec[gi])
            );
        end
    endgenerate

    // Ascending scan with strict '>' gives same-cycle ties to the lowest PE.
    always_comb begin
        best_score_next = best_score_reg;
        best_ref_next   = best_ref_reg;
        best_read_next  = best_read_reg;
        ovf_next        = ovf_reg | (|(sat_vec & pe_mask));
        for (int j = 0; j < NUM_PE; j++) begin
            if (valid_ch[j + 1] && pe_mask[j]) begin
                if (mode_reg) begin
                    if (h_ch[j + 1] > best_score_next) begin
                        best_score_next = h_ch[j + 1];
                        best_ref_next   = POS_W'(j + 1);
                        best_read_next  = row_ch[j + 1];
                    end
                end else if (pe_last[j]) begin
                    best_score_next = h_ch[j + 1];
                    best_ref_next   = POS_W'(j + 1);
                    best_read_next  = row_ch[j + 1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            mode_reg       <= 1'b0;
            match_reg      <= '0;
            mis_reg        <= '0;
            gap_reg        <= '0;
            ref_cnt_reg    <= '0;
            ref_len_reg    <= '0;
            drain_cnt_reg  <= '0;
            read_cnt_reg   <= '0;
            col0_reg       <= '0;
            best_score_reg <= '0;
            best_ref_reg   <= '0;
            best_read_reg  <= '0;
            ovf_reg        <= 1'b0;
        end else begin
            state_reg <= state_next;
            if ((state_reg == ST_IDLE) && start_i) begin
                mode_reg       <= mode_i;
                match_reg      <= match_i;
                mis_reg        <= mismatch_i;
                gap_reg        <= gap_i;
                ref_cnt_reg    <= '0;
                read_cnt_reg   <= '0;
                col0_reg       <= '0;
                best_score_reg <= '0;
                best_ref_reg   <= '0;
                best_read_reg  <= '0;
                ovf_reg        <= 1'b0;
            end
            if (ref_acc) begin
                ref_cnt_reg <= ref_cnt_reg + 1'b1;
            end
            if (ref_end) begin
                ref_len_reg <= ref_cnt_reg + 1'b1;
            end
            if (read_acc) begin
                read_cnt_reg <= read_cnt_reg + 1'b1;
                col0_reg     <= col0_next;
            end
            if (read_end) begin
                drain_cnt_reg <= ref_len_reg;
            end else if (state_reg == ST_DRAIN) begin
                drain_cnt_reg <= drain_cnt_reg - 1'b1;
            end
            if ((state_reg == ST_STREAM) || (state_reg == ST_DRAIN)) begin
                best_score_reg <= best_score_next;
                best_ref_reg   <= best_ref_next;
                best_read_reg  <= best_read_next;
                ovf_reg        <= ovf_next;
            end
        end
    end

    assign best_score_o    = best_score_reg;
    assign best_ref_pos_o  = best_ref_reg;
    assign best_read_pos_o = best_read_reg;
    assign overflow_o      = ovf_reg;

endmodule

// File: tb/tb_dna_sw_systolic.sv
// Directed bench for dna_sw_systolic: table of alignment runs with hand-computed results,
// plus reset-abort, result-hold and narrow-score saturation sequences.
module tb_dna_sw_systolic;
    import dna_sw_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, mode_i;
    logic [2:0]  match_i, mismatch_i, gap_i;
    logic        ref_valid_i, ref_last_i, read_valid_i, read_last_i;
    logic [1:0]  ref_sym_i, read_sym_i;
    logic        ref_ready_o, read_ready_o, busy_o, done_o, overflow_o;
    logic [15:0] best_score_o;
    logic [4:0]  best_ref_pos_o;
    logic [10:0] best_read_pos_o;
    logic        n_ref_ready, n_read_ready, n_busy, n_done, n_ovf;
    logic [3:0]  n_score;
    logic [4:0]  n_ref_pos;
    logic [10:0] n_read_pos;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dna_sw_systolic dut (
        .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i),
        .match_i(match_i), .mismatch_i(mismatch_i), .gap_i(gap_i),
        .ref_valid_i(ref_valid_i), .ref_ready_o(ref_ready_o), .ref_sym_i(ref_sym_i),
        .ref_last_i(ref_last_i), .read_valid_i(read_valid_i), .read_ready_o(read_ready_o),
        .read_sym_i(read_sym_i), .read_last_i(read_last_i), .busy_o(busy_o), .done_o(done_o),
        .best_score_o(best_score_o), .best_ref_pos_o(best_ref_pos_o),
        .best_read_pos_o(best_read_pos_o), .overflow_o(overflow_o)
    );

    dna_sw_systolic #(.SCORE_W(4)) dut_narrow (
        .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i),
        .match_i(match_i), .mismatch_i(mismatch_i), .gap_i(gap_i),
        .ref_valid_i(ref_valid_i), .ref_ready_o(n_ref_ready), .ref_sym_i(ref_sym_i),
        .ref_last_i(ref_last_i), .read_valid_i(read_valid_i), .read_ready_o(n_read_ready),
        .read_sym_i(read_sym_i), .read_last_i(read_last_i), .busy_o(n_busy), .done_o(n_done),
        .best_score_o(n_score), .best_ref_pos_o(n_ref_pos),
        .best_read_pos_o(n_read_pos), .overflow_o(n_ovf)
    );

    typedef struct {
        logic        mode;
        logic [2:0]  mt, mm, gp;
        logic [31:0] rf;
        int          rf_len;
        logic [31:0] rd;
        int          rd_len;
        logic        bub;
        int          exp_score, exp_ref, exp_read;
        logic        exp_ovf;
        logic        chk_narrow;
        int          n_score, n_ref, n_read;
        logic        n_ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [31:0] enc(input string s);
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < s.len(); i++) begin
            case (s[i])
                "C":     v[2*i +: 2] = 2'b01;
                "G":     v[2*i +: 2] = 2'b10;
                "T":     v[2*i +: 2] = 2'b11;
                default: v[2*i +: 2] = 2'b00;
            endcase
        end
        return v;
    endfunction

    function automatic vec_t mk(input logic mode, input int mt, input int mm, input int gp,
                                input string rf, input string rd, input logic bub,
                                input int sc, input int rp, input int dp, input logic ov);
        vec_t v;
        v.mode = mode; v.mt = 3'(mt); v.mm = 3'(mm); v.gp = 3'(gp);
        v.rf = enc(rf); v.rf_len = rf.len(); v.rd = enc(rd); v.rd_len = rd.len();
        v.bub = bub; v.exp_score = sc; v.exp_ref = rp; v.exp_read = dp; v.exp_ovf = ov;
        v.chk_narrow = 1'b0; v.n_score = 0; v.n_ref = 0; v.n_read = 0; v.n_ovf = 1'b0;
        return v;
    endfunction

    task automatic start_run(input vec_t v);
        @(negedge clk);
        start_i = 1'b1; mode_i = v.mode; match_i = v.mt; mismatch_i = v.mm; gap_i = v.gp;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic load_ref(input vec_t v);
        int n;
        for (int k = 0; k < v.rf_len; k++) begin
            ref_valid_i = 1'b1;
            ref_sym_i   = v.rf[2*k +: 2];
            ref_last_i  = (k == v.rf_len - 1) && (v.rf_len < 16);
            n = 0;
            while (!ref_ready_o && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!ref_ready_o) check("ref_ready_timeout", 0, 1);
            @(negedge clk);
        end
        ref_valid_i = 1'b0;
        ref_last_i  = 1'b0;
    endtask

    task automatic stream_read(input vec_t v, input int count);
        int n;
        for (int k = 0; k < count; k++) begin
            if (v.bub && k > 0) repeat (2) @(negedge clk);
            read_valid_i = 1'b1;
            read_sym_i   = v.rd[2*k +: 2];
            read_last_i  = (k == v.rd_len - 1);
            n = 0;
            while (!read_ready_o && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!read_ready_o) check("read_ready_timeout", 0, 1);
            @(negedge clk);
            read_valid_i = 1'b0;
            read_last_i  = 1'b0;
        end
    endtask

    // lat counts cycles after the last accept; done is expected in cycle T+ref_len+1.
    task automatic run_vec(input vec_t v, output int lat);
        start_run(v);
        load_ref(v);
        stream_read(v, v.rd_len);
        lat = 1;
        while (!done_o && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input int i, input vec_t v, input int lat);
        $display("vec %0d: lat=%0d score=%0d ref=%0d read=%0d ovf=%0d", i, lat,
                 int'($signed(best_score_o)), best_ref_pos_o, best_read_pos_o, overflow_o);
        check($sformatf("vec%0d_latency", i), lat, v.rf_len + 1);
        check($sformatf("vec%0d_score", i), int'($signed(best_score_o)), v.exp_score);
        check($sformatf("vec%0d_ref_pos", i), int'(best_ref_pos_o), v.exp_ref);
        check($sformatf("vec%0d_read_pos", i), int'(best_read_pos_o), v.exp_read);
        check($sformatf("vec%0d_overflow", i), int'(overflow_o), int'(v.exp_ovf));
        if (v.chk_narrow) begin
            check($sformatf("vec%0d_narrow_score", i), int'($signed(n_score)), v.n_score);
            check($sformatf("vec%0d_narrow_ref_pos", i), int'(n_ref_pos), v.n_ref);
            check($sformatf("vec%0d_narrow_read_pos", i), int'(n_read_pos), v.n_read);
            check($sformatf("vec%0d_narrow_overflow", i), int'(n_ovf), int'(v.n_ovf));
        end
    endtask

    initial begin
        int   lat;
        logic saw_done;

        vecs[0] = mk(1'b1, 2, 1, 1, "ACGT", "ACGT", 1'b0, 8, 4, 4, 1'b0);
        vecs[1] = mk(1'b0, 2, 1, 1, "ACGT", "AGT", 1'b0, 5, 4, 3, 1'b0);
        vecs[2] = mk(1'b1, 2, 1, 1, "AAAA", "CCCC", 1'b0, 0, 0, 0, 1'b0);
        vecs[3] = mk(1'b1, 2, 1, 1, "ACGT", "ACGT", 1'b1, 8, 4, 4, 1'b0);
        vecs[4] = mk(1'b0, 2, 1, 1, "A", "T", 1'b0, -1, 1, 1, 1'b0);
        vecs[5] = mk(1'b1, 2, 1, 1, "ACGT", "GT", 1'b0, 4, 4, 2, 1'b0);
        vecs[6] = mk(1'b0, 2, 1, 1, "AC", "ACC", 1'b0, 3, 2, 3, 1'b0);
        vecs[7] = mk(1'b1, 7, 1, 1, "AAAAAAAAAAAAAAAA", "AAAAAAAAAAAAAAAA", 1'b0,
                     112, 16, 16, 1'b0);
        vecs[7].chk_narrow = 1'b1;
        vecs[7].n_score = 7; vecs[7].n_ref = 1; vecs[7].n_read = 1; vecs[7].n_ovf = 1'b1;

        rst = 1'b1; start_i = 1'b0; mode_i = 1'b0; match_i = '0; mismatch_i = '0; gap_i = '0;
        ref_valid_i = 1'b0; ref_last_i = 1'b0; ref_sym_i = '0;
        read_valid_i = 1'b0; read_last_i = 1'b0; read_sym_i = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", int'(busy_o), 0);
        check("reset_done", int'(done_o), 0);
        check("reset_score", int'(best_score_o), 0);
        check("reset_ref_ready", int'(ref_ready_o), 0);
        check("reset_read_ready", int'(read_ready_o), 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], lat);
            check_result(i, vecs[i], lat);
        end

        // done is a single-cycle pulse and results persist in IDLE.
        @(negedge clk);
        check("done_pulse_width", int'(done_o), 0);
        check("idle_not_busy", int'(busy_o), 0);
        check("result_hold_score", int'($signed(best_score_o)), 112);
        repeat (3) @(negedge clk);
        check("result_hold_ref_pos", int'(best_ref_pos_o), 16);

        // Reset in the middle of STREAM aborts the run without done.
        start_run(vecs[0]);
        load_ref(vecs[0]);
        stream_read(vecs[0], 2);
        check("mid_stream_busy", int'(busy_o), 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("mid-stream reset: busy=%0d score=%0d ready=%0d", busy_o, best_score_o, read_ready_o);
        check("abort_busy", int'(busy_o), 0);
        check("abort_score", int'(best_score_o), 0);
        check("abort_ref_pos", int'(best_ref_pos_o), 0);
        check("abort_read_pos", int'(best_read_pos_o), 0);
        check("abort_read_ready", int'(read_ready_o), 0);
        saw_done = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            saw_done = saw_done | done_o;
        end
        check("abort_no_done", int'(saw_done), 0);

        run_vec(vecs[0], lat);
        check_result(8, vecs[0], lat);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
